// File: rtl/tty_pkg.sv
// Shared constants and command/state encodings for the VGA text-terminal write path.
// The screen is 40x30 cells and is addressed linearly as row*40+col.
package tty_pkg;

    localparam int TTY_COLS = 40;
    localparam int TTY_ROWS = 30;
    localparam int TTY_AW   = 12;

    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_ESC = 8'h1B;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    typedef enum logic [2:0] {
        CUR_NONE    = 3'd0,
        CUR_INC     = 3'd1,
        CUR_NEWLINE = 3'd2,
        CUR_BACK    = 3'd3,
        CUR_HOME    = 3'd4
    } cur_cmd_e;

endpackage

// File: rtl/tty_write_ctrl_if.sv
// CPU-bus byte strobe and VRAM write port of the terminal write controller.
// The controller side is the slave; the bus decode / bench side is the master.
interface tty_write_ctrl_if
    import tty_pkg::*;
#(
    parameter int AW = TTY_AW
);
    logic [7:0]    bus_data;
    logic          bus_wr;
    logic          busy;
    logic          ovf;
    logic          vram_we;
    logic [AW-1:0] vram_addr;
    logic [7:0]    vram_din;
    logic [AW-1:0] cur_addr;

    modport master (
        output bus_data, bus_wr,
        input  busy, ovf, vram_we, vram_addr, vram_din, cur_addr
    );

    modport slave (
        input  bus_data, bus_wr,
        output busy, ovf, vram_we, vram_addr, vram_din, cur_addr
    );
endinterface

// File: rtl/tty_cursor.sv
// Cursor position (col,row) with inc/newline/back/home commands.
// Produces the live linear cell address and a registered copy for the blink overlay.
module tty_cursor
    import tty_pkg::*;
#(
    parameter int COLS = TTY_COLS,
    parameter int ROWS = TTY_ROWS,
    parameter int AW   = TTY_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  cur_cmd_e      cmd,
    output logic [AW-1:0] lin_addr,
    output logic [AW-1:0] cur_addr,
    output logic          eos,
    output logic          last_row,
    output logic          at_home
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic [CW-1:0] col_r, col_n;
    logic [RW-1:0] row_r, row_n;
    logic [AW-1:0] cur_addr_r;
    logic [AW-1:0] row_ext_s;
    logic [AW-1:0] row_base_s;
    logic          last_col_s;

    assign last_col_s = (col_r == CW'(COLS - 1));
    assign last_row   = (row_r == RW'(ROWS - 1));
    assign eos        = last_col_s & last_row;
    assign at_home    = (col_r == {CW{1'b0}}) && (row_r == {RW{1'b0}});
    assign row_ext_s  = AW'(row_r);

    // row*40 as (row<<5)+(row<<3); other widths fall back to a multiply
    generate
        if (COLS == 40) begin : g_x40
            assign row_base_s = {row_ext_s[AW-6:0], 5'b0_0000} + {row_ext_s[AW-4:0], 3'b000};
        end else begin : g_gen
            assign row_base_s = row_ext_s * AW'(COLS);
        end
    endgenerate

    assign lin_addr = row_base_s + AW'(col_r);
    assign cur_addr = cur_addr_r;

    // Next cursor position; the last cell wraps to home, the clear sweep follows
    always_comb begin
        col_n = col_r;
        row_n = row_r;
        case (cmd)
            CUR_INC: begin
                if (last_col_s) begin
                    col_n = {CW{1'b0}};
                    row_n = last_row ? {RW{1'b0}} : row_r + 1'b1;
                end else begin
                    col_n = col_r + 1'b1;
                    row_n = row_r;
                end
            end
            CUR_NEWLINE: begin
                col_n = {CW{1'b0}};
                row_n = last_row ? {RW{1'b0}} : row_r + 1'b1;
            end
            CUR_BACK: begin
                if (col_r != {CW{1'b0}}) begin
                    col_n = col_r - 1'b1;
                    row_n = row_r;
                end else if (row_r != {RW{1'b0}}) begin
                    col_n = CW'(COLS - 1);
                    row_n = row_r - 1'b1;
                end else begin
                    col_n = col_r;
                    row_n = row_r;
                end
            end
            CUR_HOME: begin
                col_n = {CW{1'b0}};
                row_n = {RW{1'b0}};
            end
            default: begin
                col_n = col_r;
                row_n = row_r;
            end
        endcase
    end

    // Cursor registers; cur_addr trails the cursor by one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_r      <= {CW{1'b0}};
            row_r      <= {RW{1'b0}};
            cur_addr_r <= {AW{1'b0}};
        end else begin
            col_r      <= col_n;
            row_r      <= row_n;
            cur_addr_r <= lin_addr;
        end
    end
endmodule

// File: rtl/tty_write_ctrl.sv
// Sequences every write into the text VRAM: strobe edge detect, one-byte pending
// buffer, control-code decode, single-cycle writes and the full-screen clear sweep.
module tty_write_ctrl
    import tty_pkg::*;
#(
    parameter int COLS = TTY_COLS,
    parameter int ROWS = TTY_ROWS,
    parameter int AW   = TTY_AW
) (
    input  logic             clk_50mhz,
    input  logic             rst_n,
    tty_write_ctrl_if.slave  bus
);
    localparam logic [AW-1:0] LAST_CELL = AW'(COLS * ROWS - 1);
    localparam logic [AW-1:0] A_ZERO    = {AW{1'b0}};
    localparam logic [AW-1:0] A_ONE     = {{(AW-1){1'b0}}, 1'b1};

    logic          bus_wr_q_r;
    logic          event_s;
    logic [1:0]    state_r, state_n;
    logic [AW-1:0] clr_cnt_r, clr_cnt_n;
    logic          clr_after_r, clr_after_n;
    logic          pend_valid_r, pend_valid_n;
    logic [7:0]    pend_data_r, pend_data_n;
    logic          consume_s;
    logic          drop_s;
    logic          ovf_r;
    logic          dec_go_s;
    logic [7:0]    dec_byte_s;
    cur_cmd_e      cmd_s;
    logic [AW-1:0] wr_addr_s;
    logic [7:0]    wr_din_s;
    logic          vram_we_r, vram_we_n;
    logic [AW-1:0] vram_addr_r, vram_addr_n;
    logic [7:0]    vram_din_r, vram_din_n;
    logic          busy_r, busy_n;
    logic [AW-1:0] lin_addr_s;
    logic [AW-1:0] cur_addr_s;
    logic          eos_s, last_row_s, at_home_s;

    tty_cursor #(
        .COLS (COLS),
        .ROWS (ROWS),
        .AW   (AW)
    ) u_cursor (
        .clk      (clk_50mhz),
        .rst_n    (rst_n),
        .cmd      (cmd_s),
        .lin_addr (lin_addr_s),
        .cur_addr (cur_addr_s),
        .eos      (eos_s),
        .last_row (last_row_s),
        .at_home  (at_home_s)
    );

    assign event_s   = bus.bus_wr & ~bus_wr_q_r;
    assign consume_s = (state_r == ST_IDLE) && pend_valid_r;

    // Pending buffer: refilled in the same cycle its held byte is decoded
    always_comb begin
        pend_valid_n = pend_valid_r;
        pend_data_n  = pend_data_r;
        drop_s       = 1'b0;
        if (event_s) begin
            if ((state_r == ST_IDLE) && !pend_valid_r) begin
                pend_valid_n = 1'b0;
            end else if (consume_s || !pend_valid_r) begin
                pend_valid_n = 1'b1;
                pend_data_n  = bus.bus_data;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            pend_valid_n = pend_valid_r & ~consume_s;
        end
    end

    // Byte to decode this cycle: a held byte always goes ahead of a fresh strobe
    always_comb begin
        if (consume_s) begin
            dec_go_s   = 1'b1;
            dec_byte_s = pend_data_r;
        end else if ((state_r == ST_IDLE) && event_s) begin
            dec_go_s   = 1'b1;
            dec_byte_s = bus.bus_data;
        end else begin
            dec_go_s   = 1'b0;
            dec_byte_s = 8'h00;
        end
    end

    // Next-state decode; backspace target is simply the linear address minus one
    always_comb begin
        state_n     = state_r;
        cmd_s       = CUR_NONE;
        wr_addr_s   = lin_addr_s;
        wr_din_s    = 8'h00;
        clr_after_n = clr_after_r;
        case (state_r)
            ST_IDLE: begin
                if (dec_go_s) begin
                    case (dec_byte_s)
                        CH_CR: begin
                            cmd_s   = CUR_NEWLINE;
                            state_n = last_row_s ? ST_CLEAR : ST_IDLE;
                        end
                        CH_BS: begin
                            if (at_home_s) begin
                                state_n = ST_IDLE;
                            end else begin
                                cmd_s     = CUR_BACK;
                                state_n   = ST_WRITE;
                                wr_addr_s = lin_addr_s - A_ONE;
                            end
                        end
                        CH_ESC: begin
                            state_n = ST_CLEAR;
                        end
                        default: begin
                            cmd_s       = CUR_INC;
                            state_n     = ST_WRITE;
                            wr_din_s    = dec_byte_s;
                            clr_after_n = eos_s;
                        end
                    endcase
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_n     = clr_after_r ? ST_CLEAR : ST_IDLE;
                clr_after_n = 1'b0;
            end
            ST_CLEAR: begin
                if (clr_cnt_r == LAST_CELL) begin
                    state_n = ST_IDLE;
                    cmd_s   = CUR_HOME;
                end else begin
                    state_n = ST_CLEAR;
                end
            end
            default: begin
                state_n     = ST_IDLE;
                clr_after_n = 1'b0;
            end
        endcase
    end

    // Next values of the registered VRAM port, aligned with the state they belong to
    always_comb begin
        clr_cnt_n = ((state_r == ST_CLEAR) && (state_n == ST_CLEAR)) ? clr_cnt_r + A_ONE : A_ZERO;
        if (state_n == ST_CLEAR) begin
            vram_we_n   = 1'b1;
            vram_addr_n = clr_cnt_n;
            vram_din_n  = 8'h00;
        end else if (state_n == ST_WRITE) begin
            vram_we_n   = 1'b1;
            vram_addr_n = wr_addr_s;
            vram_din_n  = wr_din_s;
        end else begin
            vram_we_n   = 1'b0;
            vram_addr_n = vram_addr_r;
            vram_din_n  = vram_din_r;
        end
        busy_n = !((state_n == ST_IDLE) && !pend_valid_n);
    end

    // FSM state register with clear-sweep counter
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            clr_cnt_r   <= A_ZERO;
            clr_after_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            clr_cnt_r   <= clr_cnt_n;
            clr_after_r <= clr_after_n;
        end
    end

    // Strobe history, pending buffer and sticky overflow
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            bus_wr_q_r   <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_data_r  <= 8'h00;
            ovf_r        <= 1'b0;
        end else begin
            bus_wr_q_r   <= bus.bus_wr;
            pend_valid_r <= pend_valid_n;
            pend_data_r  <= pend_data_n;
            ovf_r        <= ovf_r | drop_s;
        end
    end

    // Registered VRAM port and busy flag
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            vram_we_r   <= 1'b0;
            vram_addr_r <= A_ZERO;
            vram_din_r  <= 8'h00;
            busy_r      <= 1'b0;
        end else begin
            vram_we_r   <= vram_we_n;
            vram_addr_r <= vram_addr_n;
            vram_din_r  <= vram_din_n;
            busy_r      <= busy_n;
        end
    end

    assign bus.vram_we   = vram_we_r;
    assign bus.vram_addr = vram_addr_r;
    assign bus.vram_din  = vram_din_r;
    assign bus.busy      = busy_r;
    assign bus.ovf       = ovf_r;
    assign bus.cur_addr  = cur_addr_s;
endmodule

// File: tb/tb_tty_write_ctrl.sv
// Bench for tty_write_ctrl: directed scenarios plus random byte streams, checked
// against a linear-cursor reference model and a log of every VRAM write.
module tb_tty_write_ctrl;
    logic clk_50mhz = 1'b0;
    logic rst_n     = 1'b0;

    tty_write_ctrl_if #(.AW(12)) bus ();

    tty_write_ctrl dut (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    int          total  = 0;
    int          passed = 0;
    logic [19:0] got_q[$];
    logic [19:0] exp_q[$];
    int          model_pos = 0;
    logic        model_ovf = 1'b0;

    // every VRAM write seen by the bench, as {addr, data}
    always @(negedge clk_50mhz) begin
        if (bus.vram_we === 1'b1) got_q.push_back({bus.vram_addr, bus.vram_din});
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int a = 0; a < 1200; a++) exp_q.push_back({12'(a), 8'h00});
        model_pos = 0;
    endtask

    // reference behaviour on a linear cursor position 0..1199
    task automatic model_apply(input logic [7:0] ch);
        if (ch == 8'h0D) begin
            if (model_pos / 40 == 29) model_clear();
            else model_pos = (model_pos / 40 + 1) * 40;
        end else if (ch == 8'h08) begin
            if (model_pos > 0) begin
                model_pos--;
                exp_q.push_back({12'(model_pos), 8'h00});
            end
        end else if (ch == 8'h1B) begin
            model_clear();
        end else begin
            exp_q.push_back({12'(model_pos), ch});
            model_pos++;
            if (model_pos == 1200) model_clear();
        end
    endtask

    task automatic strobe(input logic [7:0] ch);
        bus.bus_data = ch;
        bus.bus_wr   = 1'b1;
        @(negedge clk_50mhz);
        bus.bus_wr   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            @(negedge clk_50mhz);
            n++;
        end
        if (n >= budget) check("idle_timeout", 32'(bus.busy), 32'd0);
        @(negedge clk_50mhz);
    endtask

    task automatic send(input logic [7:0] ch);
        model_apply(ch);
        strobe(ch);
        wait_idle(3000);
    endtask

    task automatic compare_log();
        int n;
        check("log_len", 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check("log_entry", 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        bus.bus_wr = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_50mhz);
        rst_n = 1'b1;
        @(negedge clk_50mhz);
        model_pos = 0;
        model_ovf = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(32, 126));
    endfunction

    initial begin
        int          n;
        int          r;
        logic [7:0]  ch;

        bus.bus_wr   = 1'b0;
        bus.bus_data = 8'h00;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk_50mhz);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_we", 32'(bus.vram_we), 32'd0);
        check("rst_addr", 32'(bus.vram_addr), 32'd0);
        check("rst_din", 32'(bus.vram_din), 32'd0);
        check("rst_cur", 32'(bus.cur_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk_50mhz);

        // 'A' then 'B': each write lands one cycle after its strobe edge
        model_apply(8'h41);
        strobe(8'h41);
        check("A_we", 32'(bus.vram_we), 32'd1);
        check("A_addr", 32'(bus.vram_addr), 32'd0);
        check("A_din", 32'(bus.vram_din), 32'h41);
        wait_idle(100);
        model_apply(8'h42);
        strobe(8'h42);
        check("B_we", 32'(bus.vram_we), 32'd1);
        check("B_addr", 32'(bus.vram_addr), 32'd1);
        check("B_din", 32'(bus.vram_din), 32'h42);
        wait_idle(100);
        check("AB_cur", 32'(bus.cur_addr), 32'd2);
        compare_log();

        // full row wraps to (0,1); CR then moves to (0,2) without writing
        do_reset();
        for (int i = 0; i < 40; i++) send(rand_print());
        compare_log();
        check("row_wrap_cur", 32'(bus.cur_addr), 32'd40);
        send(8'h0D);
        check("cr_cur", 32'(bus.cur_addr), 32'd80);
        compare_log();

        // backspace across a row boundary, then at home
        do_reset();
        for (int i = 0; i < 40; i++) send(rand_print());
        send(8'h08);
        compare_log();
        check("bs_wrap_cur", 32'(bus.cur_addr), 32'd39);
        do_reset();
        send(8'h08);
        compare_log();
        check("bs_home_cur", 32'(bus.cur_addr), 32'd0);

        // ESC: busy exactly for the 1200-cycle sweep
        do_reset();
        for (int i = 0; i < 5; i++) send(rand_print());
        model_apply(8'h1B);
        strobe(8'h1B);
        n = 0;
        while (bus.busy === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk_50mhz);
        end
        check("clear_busy_cycles", 32'(n), 32'd1200);
        @(negedge clk_50mhz);
        compare_log();
        check("clear_cur", 32'(bus.cur_addr), 32'd0);

        // bytes during a clear: first is held, second overflows
        model_apply(8'h1B);
        strobe(8'h1B);
        repeat (100) @(negedge clk_50mhz);
        model_apply(8'h58);
        strobe(8'h58);
        repeat (100) @(negedge clk_50mhz);
        strobe(8'h51);
        model_ovf = 1'b1;
        check("ovf_set", 32'(bus.ovf), 32'(model_ovf));
        wait_idle(3000);
        compare_log();
        check("pend_cur", 32'(bus.cur_addr), 32'd1);
        check("ovf_sticky", 32'(bus.ovf), 32'(model_ovf));

        // reset in the middle of a clear aborts it
        strobe(8'h1B);
        n = 0;
        while (bus.vram_addr !== 12'd500 && n < 2000) begin
            @(negedge clk_50mhz);
            n++;
        end
        check("reach_500", 32'(bus.vram_addr), 32'd500);
        rst_n = 1'b0;
        @(negedge clk_50mhz);
        check("abort_we", 32'(bus.vram_we), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_cur", 32'(bus.cur_addr), 32'd0);
        check("abort_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk_50mhz);
        rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        model_pos = 0;
        model_ovf = 1'b0;
        repeat (50) @(negedge clk_50mhz);
        check("abort_no_writes", 32'(got_q.size()), 32'd0);

        // last cell: write at 1199 then the automatic clear
        do_reset();
        repeat (29) send(8'h0D);
        repeat (39) send(rand_print());
        compare_log();
        check("eos_pre_cur", 32'(bus.cur_addr), 32'd1199);
        send(8'h5A);
        compare_log();
        check("eos_cur", 32'(bus.cur_addr), 32'd0);

        // random byte stream against the reference model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 12) ch = 8'h0D;
            else if (r < 24) ch = 8'h08;
            else if (r < 27) ch = 8'h1B;
            else ch = rand_print();
            if (ch == 8'h1B) begin
                model_apply(ch);
                strobe(ch);
                repeat ($urandom_range(1, 1100)) @(negedge clk_50mhz);
                ch = rand_print();
                model_apply(ch);
                strobe(ch);
                wait_idle(3000);
            end else begin
                send(ch);
            end
            check("rand_cur", 32'(bus.cur_addr), 32'(model_pos));
            if (i % 25 == 24) compare_log();
        end
        compare_log();
        check("rand_ovf", 32'(bus.ovf), 32'(model_ovf));
        check("rand_busy", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
